xmpl_goertzel_bank: RTL and testbench
=====================================

# xmpl_goertzel_bank

Parametrised multi-bin spectral power engine for the xmpl DSP core. It is the configurable successor to the fixed-width FFT status block. The engine accepts a stream of signed real samples and runs NUM_BINS Goertzel recursions in parallel over blocks of 2^N_LOG2 samples. At the end of each block it emits one squared-magnitude word per bin through a ready/valid output, and it flags arithmetic saturation per block.

## Interface
- DATA_W, 16: signed sample width.
- COEF_W, 16: signed coefficient width, format Q2.(COEF_W-2), value 2·cos(2πk/N).
- N_LOG2, 6: block length N = 2^N_LOG2, range 2..12.
- NUM_BINS, 4: number of parallel bins, range 1..16.
- ACC_W, 24: signed state-register width, ACC_W ≥ DATA_W+2. Local PWR_W = 2·ACC_W.
- clk_i  in  1  clock; single clock domain.
- reset_n_i  in  1  synchronous active-low reset.
- en_i  in  1  run enable; deassertion aborts the current block.
- coef_i  in  NUM_BINS·COEF_W  bin coefficients, bin b at [b·COEF_W +: COEF_W]; sampled at block start.
- smp_vld_i  in  1  sample valid.
- smp_i  in  DATA_W  signed sample.
- smp_rdy_o  out  1  sample ready.
- pwr_vld_o  out  1  result valid.
- pwr_o  out  NUM_BINS·PWR_W  unsigned power per bin, bin b at [b·PWR_W +: PWR_W].
- pwr_rdy_i  in  1  result ready.
- ovf_o  out  1  saturation occurred in the block being reported; qualified by pwr_vld_o.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: smp_rdy_o=0. Goes to ACCUM when en_i=1.
  - ACCUM: smp_rdy_o=1. Goes to FINAL after N accepted samples. Goes to IDLE if en_i=0.
  - FINAL: lasts NUM_BINS cycles and computes one bin per cycle, index 0 upward. Goes to OUT.
  - OUT: pwr_vld_o=1. On pwr_rdy_i it goes to ACCUM if en_i=1, otherwise to IDLE.
- On entering ACCUM, the block does all of the following:
  - latches coef_i into internal registers;
  - clears s1, s2, the sample counter and the ovf flag.
- Recursion per accepted sample (smp_vld_i & smp_rdy_o), for every bin:
  - s0 = x + ((coef·s1) >>> (COEF_W-2)) − s2, with an arithmetic shift, so it truncates toward −∞;
  - s0 is saturated to the signed ACC_W range, and the ovf flag is set if clipping occurs;
  - s2 ← s1, s1 ← s0.
- Power per bin in FINAL:
  - P = s1² + s2² − (((coef·s1) >>> (COEF_W-2))·s2), computed at full precision;
  - P < 0 is clamped to 0, and P > 2^PWR_W−1 saturates and sets the ovf flag;
  - the result is written to that bin's slice of pwr_o.
- Abort:
  - en_i=0 in ACCUM or FINAL goes to IDLE and produces no output;
  - en_i=0 in OUT has no effect until the handshake completes.
- Reset values: smp_rdy_o=0, pwr_vld_o=0, pwr_o=0, ovf_o=0, busy_o=0. All state registers are 0 and the FSM is in IDLE.

## Timing
- IDLE→ACCUM takes one cycle after en_i rises. smp_rdy_o is high in the first ACCUM cycle.
- When the last (N-th) sample is accepted at the edge of cycle t:
  - smp_rdy_o is 0 from cycle t+1;
  - FINAL occupies cycles t+1 to t+NUM_BINS;
  - pwr_vld_o rises at t+NUM_BINS+1.
- Output stability: pwr_o and ovf_o are held stable while pwr_vld_o=1 and pwr_rdy_i=0.
- Handshake in the first OUT cycle: if pwr_rdy_i=1, the handshake completes that cycle and ACCUM, with smp_rdy_o=1, follows on the next cycle.
- pwr_vld_o drops in the cycle after the handshake.
- Throughput: one sample per cycle while in ACCUM. The dead time between blocks is NUM_BINS+1 cycles, plus any cycles spent stalled by pwr_rdy_i.
- coef_i changes during a block do not affect that block.
- Reset asserted mid-block takes effect on the next edge. Nothing from the interrupted block is output afterwards.

## Test plan
- Bin N/4: N_LOG2=3, NUM_BINS=1, coef=0x0000, samples 1,0,−1,0,1,0,−1,0 -> final s1=0, s2=−4; pwr_o=16, ovf_o=0; pwr_vld_o rises 2 cycles after the last sample is accepted.
- Zero input: NUM_BINS=4, mixed coefficients, 64 zero samples -> every bin slice is 0; pwr_vld_o rises 5 cycles after the last sample.
- Backpressure: pwr_rdy_i held low for 10 cycles after pwr_vld_o -> pwr_o and ovf_o stay constant and smp_rdy_o stays 0. Raising pwr_rdy_i with en_i=1 gives smp_rdy_o=1 on the next cycle, then a second block runs back-to-back.
- Abort: drop en_i after 3 samples -> IDLE next cycle, pwr_vld_o never asserts. Re-enabling and rerunning the first scenario's stimulus gives exactly 16.
- Saturation: ACC_W=18, coef=0x7FFF, constant 0x7FFF samples -> ovf_o=1 with pwr_vld_o, and the state stays within ±2^17. The next clean block reports ovf_o=0.
- Reset mid-block: assert reset_n_i=0 for 1 cycle after 5 samples -> all outputs 0 next cycle. With en_i held high, a new full block starts from cleared state.

Source files
------------

// File: rtl/xmpl_goertzel_bank.sv
// Parallel Goertzel bank: NUM_BINS recursions over blocks of 2^N_LOG2 samples,
// then one saturated squared-magnitude word per bin through a ready/valid port.
module xmpl_goertzel_bank #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int N_LOG2   = 6,
  parameter int NUM_BINS = 4,
  parameter int ACC_W    = 24
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        en_i,
  input  logic [NUM_BINS*COEF_W-1:0]  coef_i,
  input  logic                        smp_vld_i,
  input  logic signed [DATA_W-1:0]    smp_i,
  output logic                        smp_rdy_o,
  output logic                        pwr_vld_o,
  output logic [NUM_BINS*2*ACC_W-1:0] pwr_o,
  input  logic                        pwr_rdy_i,
  output logic                        ovf_o,
  output logic                        busy_o
);

  localparam int PWR_W  = 2 * ACC_W;
  localparam int IDX_W  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int SH     = COEF_W - 2;
  localparam int PROD_W = COEF_W + ACC_W;
  localparam int FB_W   = ACC_W + 2;   // |coef*s1 >>> SH| <= 2^ACC_W
  localparam int SUM_W  = ACC_W + 4;
  localparam int P_W    = 2 * ACC_W + 4;

  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [P_W-1:0]   PWR_MAX = {4'b0000, {PWR_W{1'b1}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]               state_q;
  logic [N_LOG2-1:0]        cnt_q;
  logic [IDX_W-1:0]         bin_q;
  logic                     ovf_q;
  logic signed [COEF_W-1:0] coef_q [NUM_BINS];
  logic signed [ACC_W-1:0]  s1_q   [NUM_BINS];
  logic signed [ACC_W-1:0]  s2_q   [NUM_BINS];
  logic [PWR_W-1:0]         pwr_q  [NUM_BINS];

  logic signed [PROD_W-1:0] prod [NUM_BINS];
  logic signed [FB_W-1:0]   fb   [NUM_BINS];
  logic signed [SUM_W-1:0]  sum  [NUM_BINS];
  logic signed [ACC_W-1:0]  s0   [NUM_BINS];
  logic [NUM_BINS-1:0]      clip;
  logic signed [P_W-1:0]    ps1, ps2, pfb, pwr_full;
  logic [PWR_W-1:0]         pwr_sat;
  logic                     pwr_clip;
  logic                     start;

  // A new block starts from IDLE or straight after a completed handshake.
  assign start = en_i & ((state_q == S_IDLE) | ((state_q == S_OUT) & pwr_rdy_i));

  always_comb begin
    // NOTE: every signal gets a value on every path, otherwise a latch is inferred.
    clip = '0;
    for (int b = 0; b < NUM_BINS; b++) begin
      prod[b] = PROD_W'(coef_q[b]) * PROD_W'(s1_q[b]);
      fb[b]   = FB_W'(prod[b] >>> SH);
      sum[b]  = SUM_W'(smp_i) + SUM_W'(fb[b]) - SUM_W'(s2_q[b]);
      if (sum[b] > ACC_MAX) begin
        s0[b]   = ACC_MAX[ACC_W-1:0];
        clip[b] = 1'b1;
      end else if (sum[b] < ACC_MIN) begin
        s0[b]   = ACC_MIN[ACC_W-1:0];
        clip[b] = 1'b1;
      end else begin
        s0[b]   = sum[b][ACC_W-1:0];
      end
    end
  end

  // Power of the bin selected by bin_q, at full precision before clamping.
  always_comb begin
    ps1      = P_W'(s1_q[bin_q]);
    ps2      = P_W'(s2_q[bin_q]);
    pfb      = P_W'(fb[bin_q]);
    pwr_full = ps1 * ps1 + ps2 * ps2 - pfb * ps2;
    pwr_clip = 1'b0;
    if (pwr_full[P_W-1]) begin
      pwr_sat = '0;
    end else if (pwr_full > PWR_MAX) begin
      pwr_sat  = '1;
      pwr_clip = 1'b1;
    end else begin
      pwr_sat = pwr_full[PWR_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      // NOTE: these per-bin arrays are small register files, so they are reset like any other state.
      for (int b = 0; b < NUM_BINS; b++) begin
        coef_q[b] <= '0;
        s1_q[b]   <= '0;
        s2_q[b]   <= '0;
        pwr_q[b]  <= '0;
      end
    end else begin
      if (start) begin
        cnt_q <= '0;
        bin_q <= '0;
        ovf_q <= 1'b0;
        for (int b = 0; b < NUM_BINS; b++) begin
          coef_q[b] <= coef_i[b*COEF_W +: COEF_W];
          s1_q[b]   <= '0;
          s2_q[b]   <= '0;
        end
      end
      case (state_q)
        S_IDLE: if (en_i) state_q <= S_ACCUM;
        S_ACCUM: begin
          if (!en_i) begin
            state_q <= S_IDLE;
          end else if (smp_vld_i) begin
            for (int b = 0; b < NUM_BINS; b++) begin
              s2_q[b] <= s1_q[b];
              s1_q[b] <= s0[b];
            end
            ovf_q <= ovf_q | (|clip);
            cnt_q <= cnt_q + N_LOG2'(1);
            if (&cnt_q) state_q <= S_FINAL;
          end
        end
        S_FINAL: begin
          if (!en_i) begin
            state_q <= S_IDLE;
          end else begin
            pwr_q[bin_q] <= pwr_sat;
            if (pwr_clip) ovf_q <= 1'b1;
            if (bin_q == IDX_W'(NUM_BINS - 1)) state_q <= S_OUT;
            else bin_q <= bin_q + IDX_W'(1);
          end
        end
        default: if (pwr_rdy_i) state_q <= en_i ? S_ACCUM : S_IDLE;
      endcase
    end
  end

  always_comb begin
    pwr_o = '0;
    for (int b = 0; b < NUM_BINS; b++) pwr_o[b*PWR_W +: PWR_W] = pwr_q[b];
  end

  assign smp_rdy_o = (state_q == S_ACCUM);
  assign pwr_vld_o = (state_q == S_OUT);
  assign ovf_o     = ovf_q & (state_q == S_OUT);
  assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_xmpl_goertzel_bank.sv
// Bench for xmpl_goertzel_bank: directed table plus random blocks against an
// arithmetic reference model, then abort, backpressure and reset corner cases.
module tb_xmpl_goertzel_bank;

  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int N_LOG2   = 3;
  localparam int NUM_BINS = 4;
  localparam int ACC_W    = 18;
  localparam int N        = 1 << N_LOG2;
  localparam int PWR_W    = 2 * ACC_W;
  localparam int NV       = 5;
  localparam int NTOT     = 25;

  typedef struct packed {
    logic [NUM_BINS-1:0][COEF_W-1:0] coef;
    logic [N-1:0][DATA_W-1:0]        smp;
    logic [NUM_BINS-1:0][PWR_W-1:0]  pwr;
    logic                            pwr_known;
    logic                            ovf_known;
    logic                            ovf;
  } vec_t;

  vec_t vecs [NTOT];

  logic                        clk = 1'b0;
  logic                        reset_n, en, smp_vld, pwr_rdy;
  logic [NUM_BINS*COEF_W-1:0]  coef;
  logic [DATA_W-1:0]           smp;
  logic                        smp_rdy, pwr_vld, ovf, busy;
  logic [NUM_BINS*PWR_W-1:0]   pwr;

  int     n_checks = 0;
  int     n_err    = 0;
  int     blk_coef [NUM_BINS];
  int     blk_smp  [N];
  longint exp_pwr  [NUM_BINS];
  logic   exp_ovf;

  always #5 clk = ~clk;

  xmpl_goertzel_bank #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .N_LOG2(N_LOG2), .NUM_BINS(NUM_BINS), .ACC_W(ACC_W)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .coef_i(coef),
    .smp_vld_i(smp_vld), .smp_i(smp), .smp_rdy_o(smp_rdy),
    .pwr_vld_o(pwr_vld), .pwr_o(pwr), .pwr_rdy_i(pwr_rdy),
    .ovf_o(ovf), .busy_o(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Goertzel block computed straight from the recurrence with wide integers.
  task automatic run_model();
    longint lim_hi = (longint'(1) << (ACC_W - 1)) - 1;
    longint lim_lo = -(longint'(1) << (ACC_W - 1));
    longint p_max  = (longint'(1) << PWR_W) - 1;
    exp_ovf = 1'b0;
    for (int b = 0; b < NUM_BINS; b++) begin
      longint c, s1, s2, s0, p;
      c = blk_coef[b]; s1 = 0; s2 = 0;
      for (int n = 0; n < N; n++) begin
        s0 = longint'(blk_smp[n]) + ((c * s1) >>> (COEF_W - 2)) - s2;
        if (s0 > lim_hi) begin s0 = lim_hi; exp_ovf = 1'b1; end
        if (s0 < lim_lo) begin s0 = lim_lo; exp_ovf = 1'b1; end
        s2 = s1;
        s1 = s0;
      end
      p = s1 * s1 + s2 * s2 - ((c * s1) >>> (COEF_W - 2)) * s2;
      if (p < 0) p = 0;
      if (p > p_max) begin p = p_max; exp_ovf = 1'b1; end
      exp_pwr[b] = p;
    end
  endtask

  task automatic load_block(input int j);
    for (int b = 0; b < NUM_BINS; b++) blk_coef[b] = 32'(signed'(vecs[j].coef[b]));
    for (int n = 0; n < N; n++) blk_smp[n] = 32'(signed'(vecs[j].smp[n]));
    run_model();
    if (vecs[j].pwr_known)
      for (int b = 0; b < NUM_BINS; b++) exp_pwr[b] = longint'(vecs[j].pwr[b]);
    if (vecs[j].ovf_known) exp_ovf = vecs[j].ovf;
  endtask

  // Offers blk_smp[0..count-1]; coef_i is scrambled once the block has latched it.
  task automatic feed(input int count, input bit gaps);
    int   i = 0;
    int   guard = 0;
    logic acc;
    while (i < count && guard < 500) begin
      smp_vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      smp     = DATA_W'(blk_smp[i]);
      if (smp_rdy) coef = {$urandom, $urandom};
      acc = smp_vld & smp_rdy;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    smp_vld = 1'b0;
    check("feed_accepted", 64'(i), 64'(count));
  endtask

  // Entered one step after the edge that accepted the last sample.
  task automatic finish_block(input int j, input int stall, input logic [63:0] next_coef);
    logic [NUM_BINS*PWR_W-1:0] snap;
    logic snap_ovf;
    int   lat = 0;
    check($sformatf("b%0d_rdy_after_last", j), 64'(smp_rdy), 64'(0));
    while (!pwr_vld && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("b%0d_latency", j), 64'(lat), 64'(NUM_BINS));
    snap     = pwr;
    snap_ovf = ovf;
    for (int k = 0; k < stall; k++) begin
      coef = {$urandom, $urandom};
      @(posedge clk); #1;
      check($sformatf("b%0d_bp_rdy_low", j), 64'(smp_rdy), 64'(0));
    end
    if (stall > 0) begin
      check($sformatf("b%0d_bp_pwr_hold", j), 64'(pwr == snap), 64'(1));
      check($sformatf("b%0d_bp_ovf_hold", j), 64'(ovf), 64'(snap_ovf));
    end
    coef    = next_coef;
    pwr_rdy = 1'b1;
    check($sformatf("b%0d_vld", j), 64'(pwr_vld), 64'(1));
    for (int b = 0; b < NUM_BINS; b++)
      check($sformatf("b%0d_pwr_bin%0d", j, b), 64'(pwr[b*PWR_W +: PWR_W]), 64'(exp_pwr[b]));
    check($sformatf("b%0d_ovf", j), 64'(ovf), 64'(exp_ovf));
    @(posedge clk); #1;
    pwr_rdy = 1'b0;
    check($sformatf("b%0d_vld_drop", j), 64'(pwr_vld), 64'(0));
    check($sformatf("b%0d_rdy_next", j), 64'(smp_rdy), 64'(en));
  endtask

  initial begin
    int pat [N] = '{1, 0, -1, 0, 1, 0, -1, 0};

    // Directed vectors: bin N/4 tone, zero input, DC with mixed coefs, saturation, negated tone.
    for (int j = 0; j < NV; j++) vecs[j] = '0;
    for (int n = 0; n < N; n++) begin
      vecs[0].smp[n] = DATA_W'(pat[n]);
      vecs[2].smp[n] = DATA_W'(1);
      vecs[3].smp[n] = 16'h7FFF;
      vecs[4].smp[n] = DATA_W'(-pat[n]);
    end
    vecs[0].pwr = {NUM_BINS{36'd16}};
    vecs[1].coef = {16'hA57E, 16'h0000, 16'h5A82, 16'h7FFF};
    vecs[2].coef = {16'h7FFF, 16'h8000, 16'h0000, 16'h4000};
    vecs[2].pwr  = {36'd8, 36'd0, 36'd0, 36'd3};
    vecs[3].coef = {NUM_BINS{16'h7FFF}};
    vecs[3].ovf  = 1'b1;
    vecs[4].pwr  = {NUM_BINS{36'd16}};
    for (int j = 0; j < NV; j++) begin
      vecs[j].pwr_known = (j != 3);
      vecs[j].ovf_known = 1'b1;
    end
    for (int j = NV; j < NTOT; j++) begin
      vecs[j] = '0;
      vecs[j].coef = {$urandom, $urandom};
      for (int n = 0; n < N; n++)
        vecs[j].smp[n] = (j % 3 == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 4000) - 2000);
    end

    reset_n = 1'b0; en = 1'b0; coef = '0; smp_vld = 1'b0; smp = '0; pwr_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_smp_rdy", 64'(smp_rdy), 64'(0));
    check("rst_pwr_vld", 64'(pwr_vld), 64'(0));
    check("rst_pwr_zero", 64'(pwr != '0), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    reset_n = 1'b1;
    coef    = vecs[0].coef;
    en      = 1'b1;
    @(posedge clk); #1;
    check("start_rdy", 64'(smp_rdy), 64'(1));
    check("start_busy", 64'(busy), 64'(1));

    for (int j = 0; j < NTOT; j++) begin
      load_block(j);
      feed(N, (j == 2) || (j >= NV));
      finish_block(j, (j == 1) ? 10 : ((j >= NV) ? int'($urandom_range(0, 3)) : 0),
                   (j + 1 < NTOT) ? vecs[j+1].coef : vecs[0].coef);
    end

    // Abort after three samples, then a clean rerun of the tone block.
    load_block(0);
    feed(3, 1'b0);
    en = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_rdy", 64'(smp_rdy), 64'(0));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort_no_vld", 64'(pwr_vld), 64'(0));
    end
    coef = vecs[0].coef;
    en   = 1'b1;
    @(posedge clk); #1;
    check("rerun_rdy", 64'(smp_rdy), 64'(1));
    feed(N, 1'b0);
    finish_block(100, 0, vecs[2].coef);

    // Abort during the power phase.
    load_block(2);
    feed(N, 1'b0);
    en = 1'b0;
    @(posedge clk); #1;
    check("final_abort_busy", 64'(busy), 64'(0));
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("final_abort_no_vld", 64'(pwr_vld), 64'(0));
    end

    // Reset after five samples with en_i held high.
    coef = vecs[2].coef;
    en   = 1'b1;
    @(posedge clk); #1;
    load_block(5);
    feed(5, 1'b0);
    coef    = vecs[6].coef;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_rdy", 64'(smp_rdy), 64'(0));
    check("mid_rst_vld", 64'(pwr_vld), 64'(0));
    check("mid_rst_pwr_zero", 64'(pwr != '0), 64'(0));
    check("mid_rst_ovf", 64'(ovf), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rdy", 64'(smp_rdy), 64'(1));
    load_block(6);
    feed(N, 1'b1);
    finish_block(101, 2, vecs[0].coef);
    en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
